intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Bus-mapped interrupt controller sitting downstream of the device IRQ lines (Timer0/Timer1 IRQ_O and future devices) and directly upstream of the CPU HWInt[7:2] input.
- Latches device requests, applies per-source mode (level/edge), mask and global enable, and drives the masked request vector to the CPU.
- Register access goes through the bridge exactly like any other device slot: word address, write enable, 32-bit data.

Parameters:
- N_SRC, 6, number of interrupt sources; legal range 1..8; source i drives IRQ_O[i] (HWInt[i+2]).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- ADD_I  input  4  byte address within the device; ADD_I[3:2] selects the register; ADD_I[1:0] ignored.
- WE_I  input  1  register write strobe, sampled on clk rising edge.
- DAT_I  input  32  write data.
- DAT_O  output  32  read data, combinational from ADD_I and registered state.
- IRQ_I  input  N_SRC  raw device requests, synchronous to clk.
- IRQ_O  output  N_SRC  masked requests to the CPU HWInt.

Behaviour:
- Reset state: all of the following are 0: GIE, MASK, MODE, PEND, and prev (the per-source last-sampled IRQ_I). IRQ_O is therefore 0 and DAT_O reads 0 at every address.
- Register map (ADD_I[3:2]):
  - 0, CTRL: bit0 = GIE (read/write); all other bits read 0.
  - 1, MASK: bits [N_SRC-1:0] read/write; 1 = enabled.
  - 2, MODE: bits [N_SRC-1:0] read/write; 1 = edge, 0 = level.
  - 3, PEND: read returns:
    - [N_SRC-1:0] = PEND;
    - [18:16] = index of the lowest-numbered set bit of (PEND & MASK);
    - [31] = 1 if (PEND & MASK) is nonzero.
    - When [31] = 0, [18:16] reads 0. All other bits read 0.
  - Unimplemented bits of every register read 0; writes to them are ignored.
- Per-source update, every clock:
  - prev <= IRQ_I.
  - Level mode: PEND[i] <= IRQ_I[i]. W1C writes have no effect.
  - Edge mode:
    - Set when IRQ_I[i] & ~prev[i].
    - Cleared by a write to PEND with DAT_I[i] = 1.
    - Set wins over clear in the same cycle.
  - A MODE write that changes bit i clears PEND[i] in that cycle (for the level case, the following cycle's sample repopulates it).
- Output: IRQ_O = PEND & MASK & {N_SRC{GIE}}, combinational from registers.
- Latency:
  - An IRQ_I change sampled at edge k is visible on IRQ_O after edge k (1 cycle).
  - A MASK or GIE write at edge k takes effect on IRQ_O after edge k.
  - A W1C at edge k drops IRQ_O after edge k.
- Boundary cases:
  - An edge-mode source held high sets PEND once; it does not re-set until IRQ_I falls and rises again.
  - A 1-cycle pulse is captured in edge mode. In level mode it shows for exactly 1 cycle.
  - Reset asserted mid-operation clears everything asynchronously, with no clock required. prev = 0 at reset, so an edge-mode input already high when reset releases registers a rising edge on the first clock.
  - Reads have no side effects.

Decomposition:
- Shared package:
  - register index constants (CTRL=0, MASK=1, MODE=2, PEND=3);
  - PEND read field positions (IDX_LSB=16, IDX_W=3, ANY_BIT=31);
  - MODE encodings (LEVEL=0, EDGE=1).
- Sub-module intr_src_cell, one instance per source, holding prev, the PEND bit, and the edge/level/W1C/mode-change logic.
- Top level contains the register file, read mux and priority encoder.

Test Plan:
- Reset, then read addresses 0x0/0x4/0x8/0xC -> all 0x00000000; IRQ_O = 0. Assert reset with no clock while PEND = 0x3F -> IRQ_O = 0 immediately.
- Write CTRL=1, MASK=0x01, MODE=0x01; pulse IRQ_I[0] for 1 cycle -> IRQ_O[0] = 1 the cycle after sampling and stays 1; read 0xC = 0x80000001. Write 0xC = 0x1 -> IRQ_O[0] = 0 next cycle; read 0xC = 0x00000000.
- Level: MODE=0, MASK=0x04, GIE=1; hold IRQ_I[2] high 5 cycles -> IRQ_O[2] high for 5 cycles, delayed 1. A W1C write of 0x4 during this has no effect. IRQ_O[2] falls 1 cycle after IRQ_I[2] falls.
- Edge source 1: W1C of 0x2 in the same cycle as a new rising edge on IRQ_I[1] -> PEND[1] stays 1; IRQ_O[1] stays 1.
- Priority: PEND = 0x28 (sources 3 and 5), MASK = 0x28 -> read 0xC = 0x80030028. Write MASK = 0x20 -> read 0xC = 0x80050028. Write GIE = 0 -> IRQ_O = 0 while PEND is unchanged.
- Mode change: edge source 4 pending, write MODE bit4 = 0 while IRQ_I[4] = 0 -> PEND[4] = 0 and IRQ_O[4] = 0 next cycle.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register indices, PEND read fields, mode encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package intr_ctrl_pkg;

  // Register selected by ADD_I[3:2]
  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_MASK = 2'd1,
    REG_MODE = 2'd2,
    REG_PEND = 2'd3
  } reg_idx_e;

  // PEND read-back layout: pending bits at the bottom, winner index, "any" flag
  localparam int IDX_LSB = 16;
  localparam int IDX_W   = 3;
  localparam int ANY_BIT = 31;

  // Per-source MODE bit meaning
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/intr_src_cell.sv
// One interrupt source: last-sample register and pending bit with level/edge/W1C/mode-change rules.
// Latency: IRQ change sampled at edge k shows on pend_o after edge k.
// Backpressure: none; updates every clock.
`timescale 1ns/1ps
module intr_src_cell
  import intr_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  input  logic mode_i,
  input  logic mode_chg_i,
  input  logic w1c_i,
  output logic pend_o
);

  logic prev_q;
  logic pend_q;
  logic pend_d;

  // Next pending value: a mode flip discards stale state; level follows the input;
  // edge latches a rise, and a rise beats a simultaneous W1C.
  always_comb begin
    pend_d = pend_q;
    if (mode_chg_i) begin
      pend_d = 1'b0;
    end else if (mode_i == MODE_LEVEL) begin
      pend_d = irq_i;
    end else if (irq_i && !prev_q) begin
      pend_d = 1'b1;
    end else if (w1c_i) begin
      pend_d = 1'b0;
    end
  end

  // State registers; prev clears on reset so an input already high registers a rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= irq_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/intr_ctrl.sv
// Bus-mapped interrupt controller: CTRL/MASK/MODE/PEND registers, per-source latching, masked IRQ out.
// Latency: IRQ_I, MASK/GIE writes and W1C all reach IRQ_O one edge later; DAT_O is combinational.
// Backpressure: none; writes always accepted, reads have no side effects.
`timescale 1ns/1ps
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ADD_I,
  input  logic             WE_I,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  input  logic [N_SRC-1:0] IRQ_I,
  output logic [N_SRC-1:0] IRQ_O
);

  reg_idx_e         reg_sel;
  logic             gie_q, gie_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] mode_chg;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] pend_act;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_any;
  logic             unused_bits;

  assign reg_sel     = reg_idx_e'(ADD_I[3:2]);
  assign unused_bits = ^{DAT_I[31:N_SRC], ADD_I[1:0]};

  // Register-file next state from the write strobe
  always_comb begin
    gie_d  = gie_q;
    mask_d = mask_q;
    mode_d = mode_q;
    if (WE_I) begin
      case (reg_sel)
        REG_CTRL: gie_d  = DAT_I[0];
        REG_MASK: mask_d = DAT_I[N_SRC-1:0];
        REG_MODE: mode_d = DAT_I[N_SRC-1:0];
        default:  ;
      endcase
    end
  end

  // Per-source side effects of MODE and PEND writes
  always_comb begin
    mode_chg = '0;
    w1c      = '0;
    if (WE_I && reg_sel == REG_MODE) mode_chg = DAT_I[N_SRC-1:0] ^ mode_q;
    if (WE_I && reg_sel == REG_PEND) w1c      = DAT_I[N_SRC-1:0];
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gie_q  <= 1'b0;
      mask_q <= '0;
      mode_q <= '0;
    end else begin
      gie_q  <= gie_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    intr_src_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .irq_i      (IRQ_I[g]),
      .mode_i     (mode_q[g]),
      .mode_chg_i (mode_chg[g]),
      .w1c_i      (w1c[g]),
      .pend_o     (pend[g])
    );
  end

  assign pend_act = pend & mask_q;
  assign pend_any = |pend_act;
  assign IRQ_O    = pend_act & {N_SRC{gie_q}};

  // Lowest-numbered enabled pending source wins; scan downward so the last hit is the lowest
  always_comb begin
    pend_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend_act[i]) pend_idx = IDX_W'(i);
    end
  end

  // Read mux; unimplemented bits stay 0
  always_comb begin
    DAT_O = '0;
    case (reg_sel)
      REG_CTRL: DAT_O[0]         = gie_q;
      REG_MASK: DAT_O[N_SRC-1:0] = mask_q;
      REG_MODE: DAT_O[N_SRC-1:0] = mode_q;
      REG_PEND: begin
        DAT_O[N_SRC-1:0] = pend;
        DAT_O[ANY_BIT]   = pend_any;
        if (pend_any) DAT_O[IDX_LSB +: IDX_W] = pend_idx;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed vector table, reset corner cases, randomized model check.
// Latency: expects IRQ_O/DAT_O effects one edge after the sampled inputs.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_intr_ctrl;

  localparam int N = 6;

  logic          clk;
  logic          reset;
  logic [3:0]    ADD_I;
  logic          WE_I;
  logic [31:0]   DAT_I;
  logic [31:0]   DAT_O;
  logic [N-1:0]  IRQ_I;
  logic [N-1:0]  IRQ_O;

  int tests;
  int fails;

  intr_ctrl #(.N_SRC(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ADD_I (ADD_I),
    .WE_I  (WE_I),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .IRQ_I (IRQ_I),
    .IRQ_O (IRQ_O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit           m_gie;
  logic [N-1:0] m_mask, m_mode, m_pend, m_prev;

  task automatic model_reset();
    m_gie = 0; m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0;
  endtask

  // One clock of the controller's rules, applied to the inputs about to be sampled
  task automatic model_step(input logic we, input logic [3:0] a, input logic [31:0] d,
                            input logic [N-1:0] irq);
    logic [N-1:0] np;
    int r;
    r = int'(a[3:2]);
    for (int i = 0; i < N; i++) begin
      if (we && r == 2 && d[i] != m_mode[i])       np[i] = 1'b0;
      else if (!m_mode[i])                         np[i] = irq[i];
      else if (irq[i] && !m_prev[i])               np[i] = 1'b1;
      else if (we && r == 3 && d[i])               np[i] = 1'b0;
      else                                         np[i] = m_pend[i];
    end
    m_pend = np;
    m_prev = irq;
    if (we && r == 0) m_gie  = d[0];
    if (we && r == 1) m_mask = d[N-1:0];
    if (we && r == 2) m_mode = d[N-1:0];
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0]  res;
    logic [N-1:0] pm;
    int           idx;
    bit           found;
    res = 0;
    case (int'(a[3:2]))
      0: res = m_gie ? 32'd1 : 32'd0;
      1: res = 32'(m_mask);
      2: res = 32'(m_mode);
      default: begin
        pm    = m_pend & m_mask;
        found = 0;
        idx   = 0;
        for (int i = 0; i < N; i++) if (!found && pm[i]) begin idx = i; found = 1; end
        res = 32'(m_pend);
        if (found) res = res + (32'(idx) << 16) + 32'h8000_0000;
      end
    endcase
    return res;
  endfunction

  function automatic logic [N-1:0] model_irq();
    return m_gie ? (m_pend & m_mask) : '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock, keeping the model in step with the sampled inputs
  task automatic cyc();
    model_step(WE_I, ADD_I, DAT_I, IRQ_I);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         we;
    logic [3:0]   addr;
    logic [31:0]  dat;
    logic [N-1:0] irq;
    logic [3:0]   rd;
    logic [N-1:0] exp_irq;
    logic [31:0]  exp_dat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic we, input logic [3:0] addr, input logic [31:0] dat,
                              input logic [N-1:0] irq, input logic [3:0] rd,
                              input logic [N-1:0] exp_irq, input logic [31:0] exp_dat);
    vec_t v;
    v.we = we; v.addr = addr; v.dat = dat; v.irq = irq;
    v.rd = rd; v.exp_irq = exp_irq; v.exp_dat = exp_dat;
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    WE_I  = 1'b0;
    ADD_I = 4'h0;
    DAT_I = 32'h0;
    IRQ_I = '0;
    model_reset();

    // Reset state at every address
    #3;
    chk("reset IRQ_O", 32'(IRQ_O), 32'h0);
    for (int a = 0; a < 16; a += 4) begin
      ADD_I = 4'(a);
      #1;
      chk($sformatf("reset read 0x%0h", a), DAT_O, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ADD_I = 4'h0;

    // Edge src0, level src2, edge src1 set-vs-clear, priority, mode change, level pulse, ignored bits
    vq.push_back(mk(1, 4'h0, 32'h1,        6'h00, 4'h0, 6'h00, 32'h1));
    vq.push_back(mk(1, 4'h4, 32'h1,        6'h00, 4'h4, 6'h00, 32'h1));
    vq.push_back(mk(1, 4'h8, 32'h1,        6'h00, 4'h8, 6'h00, 32'h1));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h01, 4'hC, 6'h01, 32'h8000_0001));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h00, 4'hC, 6'h01, 32'h8000_0001));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h00, 4'hC, 6'h01, 32'h8000_0001));
    vq.push_back(mk(1, 4'hC, 32'h1,        6'h00, 4'hC, 6'h00, 32'h0));
    vq.push_back(mk(1, 4'h8, 32'h0,        6'h00, 4'h8, 6'h00, 32'h0));
    vq.push_back(mk(1, 4'h4, 32'h4,        6'h00, 4'h4, 6'h00, 32'h4));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h04, 4'hC, 6'h04, 32'h8002_0004));
    vq.push_back(mk(1, 4'hC, 32'h4,        6'h04, 4'hC, 6'h04, 32'h8002_0004));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h04, 4'h0, 6'h04, 32'h1));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h04, 4'hC, 6'h04, 32'h8002_0004));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h04, 4'h8, 6'h04, 32'h0));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h00, 4'hC, 6'h00, 32'h0));
    vq.push_back(mk(1, 4'h8, 32'h2,        6'h00, 4'h8, 6'h00, 32'h2));
    vq.push_back(mk(1, 4'h4, 32'h2,        6'h00, 4'h4, 6'h00, 32'h2));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h02, 4'hC, 6'h02, 32'h8001_0002));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h00, 4'hC, 6'h02, 32'h8001_0002));
    vq.push_back(mk(1, 4'hC, 32'h2,        6'h02, 4'hC, 6'h02, 32'h8001_0002));
    vq.push_back(mk(1, 4'hC, 32'h2,        6'h02, 4'hC, 6'h00, 32'h0));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h02, 4'hC, 6'h00, 32'h0));
    vq.push_back(mk(1, 4'h8, 32'h28,       6'h00, 4'h8, 6'h00, 32'h28));
    vq.push_back(mk(1, 4'h4, 32'h28,       6'h28, 4'hC, 6'h28, 32'h8003_0028));
    vq.push_back(mk(1, 4'h4, 32'h20,       6'h00, 4'hC, 6'h20, 32'h8005_0028));
    vq.push_back(mk(1, 4'h0, 32'h0,        6'h00, 4'hC, 6'h00, 32'h8005_0028));
    vq.push_back(mk(1, 4'h0, 32'h1,        6'h00, 4'h0, 6'h20, 32'h1));
    vq.push_back(mk(1, 4'h8, 32'h38,       6'h00, 4'h8, 6'h20, 32'h38));
    vq.push_back(mk(1, 4'h4, 32'h30,       6'h10, 4'hC, 6'h30, 32'h8004_0038));
    vq.push_back(mk(1, 4'h8, 32'h28,       6'h00, 4'hC, 6'h20, 32'h8005_0028));
    vq.push_back(mk(1, 4'h4, 32'h1,        6'h00, 4'hC, 6'h00, 32'h28));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h01, 4'hC, 6'h01, 32'h8000_0029));
    vq.push_back(mk(0, 4'h0, 32'h0,        6'h00, 4'hC, 6'h00, 32'h28));
    vq.push_back(mk(1, 4'h0, 32'hFFFF_FFFE,6'h00, 4'h0, 6'h00, 32'h0));
    vq.push_back(mk(1, 4'h1, 32'hFFFF_FFFF,6'h00, 4'h0, 6'h00, 32'h1));
    vq.push_back(mk(1, 4'h4, 32'hFFFF_FFFF,6'h00, 4'h4, 6'h28, 32'h3F));

    foreach (vq[k]) begin
      WE_I  = vq[k].we;
      ADD_I = vq[k].addr;
      DAT_I = vq[k].dat;
      IRQ_I = vq[k].irq;
      cyc();
      WE_I  = 1'b0;
      ADD_I = vq[k].rd;
      #1;
      chk($sformatf("vec%0d IRQ_O", k), 32'(IRQ_O), 32'(vq[k].exp_irq));
      chk($sformatf("vec%0d DAT_O", k), DAT_O, vq[k].exp_dat);
    end

    // Fill PEND with all sources in level mode, then hit reset between clock edges
    WE_I = 1'b1; ADD_I = 4'h8; DAT_I = 32'h0; IRQ_I = 6'h3F;
    cyc();
    WE_I = 1'b0; ADD_I = 4'hC;
    cyc();
    chk("prefill IRQ_O", 32'(IRQ_O), 32'h3F);
    chk("prefill PEND", DAT_O, 32'h8000_003F);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset IRQ_O", 32'(IRQ_O), 32'h0);
    chk("async reset PEND", DAT_O, 32'h0);
    model_reset();
    @(posedge clk); #1;
    for (int a = 0; a < 12; a += 4) begin
      ADD_I = 4'(a);
      #1;
      chk($sformatf("held reset read 0x%0h", a), DAT_O, 32'h0);
    end
    IRQ_I = '0;
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      WE_I  = ($urandom_range(0, 2) == 0);
      ADD_I = 4'($urandom);
      DAT_I = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) IRQ_I = N'($urandom);
      cyc();
      WE_I = 1'b0;
      ra   = 4'($urandom);
      ADD_I = ra;
      #1;
      chk($sformatf("rand%0d IRQ_O", n), 32'(IRQ_O), 32'(model_irq()));
      chk($sformatf("rand%0d read 0x%0h", n, ra), DAT_O, model_read(ra));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
